// File: rtl/tick_generator.sv
// Timebase for the digital clock: seconds, half-second, blink and display-refresh strobes.
// Optional macro TICKGEN_SPEEDUP_EN enables the speed_sel_i time-scaling for setting/test.
module tick_generator #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] speed_sel_i,
    output logic       tick_1hz_o,
    output logic       tick_2hz_o,
    output logic       blink_o,
    output logic       tick_refresh_o
);

    localparam int unsigned SEC_W   = $clog2(CLK_HZ);
    localparam int unsigned REF_DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned REF_W   = $clog2(REF_DIV);

    localparam logic [31:0] TERM_0   = 32'(CLK_HZ - 1);
    localparam logic [31:0] HALF_0   = 32'((TERM_0 + 32'd1) / 32'd2 - 32'd1);
    localparam logic [31:0] REF_LAST = 32'(REF_DIV - 1);

    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             tick_1hz_d, tick_2hz_d, blink_d, tick_ref_d;
    logic [31:0]      term_c, half_c;

`ifdef TICKGEN_SPEEDUP_EN
    localparam logic [31:0] TERM_1 = 32'(CLK_HZ / 10 - 1);
    localparam logic [31:0] TERM_2 = 32'(CLK_HZ / 100 - 1);
    localparam logic [31:0] TERM_3 = 32'(CLK_HZ / 1000 - 1);
    localparam logic [31:0] HALF_1 = 32'((TERM_1 + 32'd1) / 32'd2 - 32'd1);
    localparam logic [31:0] HALF_2 = 32'((TERM_2 + 32'd1) / 32'd2 - 32'd1);
    localparam logic [31:0] HALF_3 = 32'((TERM_3 + 32'd1) / 32'd2 - 32'd1);

    logic [1:0] spd_q, spd_d;

    // Terminal and half counts for the currently active speed
    always_comb begin
        term_c = TERM_0;
        half_c = HALF_0;
        case (spd_q)
            2'd1: begin term_c = TERM_1; half_c = HALF_1; end
            2'd2: begin term_c = TERM_2; half_c = HALF_2; end
            2'd3: begin term_c = TERM_3; half_c = HALF_3; end
            default: ;
        endcase
    end
`else
    logic [1:0] unused_speed_sel;

    assign unused_speed_sel = speed_sel_i;
    assign term_c           = TERM_0;
    assign half_c           = HALF_0;
`endif

    // Seconds channel: clear beats speed change, which beats counting
    always_comb begin
        sec_cnt_d  = sec_cnt_q;
        tick_1hz_d = 1'b0;
        tick_2hz_d = 1'b0;
        blink_d    = blink_o;
`ifdef TICKGEN_SPEEDUP_EN
        spd_d      = spd_q;
`endif
        if (clr_i) begin
            sec_cnt_d = '0;
            blink_d   = 1'b1;
        end
`ifdef TICKGEN_SPEEDUP_EN
        else if (speed_sel_i != spd_q) begin
            spd_d     = speed_sel_i;
            sec_cnt_d = '0;
            blink_d   = 1'b1;
        end
`endif
        else if (en_i) begin
            if (32'(sec_cnt_q) == term_c) begin
                sec_cnt_d  = '0;
                tick_1hz_d = 1'b1;
                tick_2hz_d = 1'b1;
                blink_d    = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_W'(1);
                if (32'(sec_cnt_q) == half_c) begin
                    tick_2hz_d = 1'b1;
                    blink_d    = 1'b0;
                end
            end
        end
    end

    // Refresh channel free-runs independently of enable, clear and speed
    always_comb begin
        tick_ref_d = (32'(ref_cnt_q) == REF_LAST);
        ref_cnt_d  = tick_ref_d ? '0 : ref_cnt_q + REF_W'(1);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sec_cnt_q      <= '0;
            ref_cnt_q      <= '0;
            tick_1hz_o     <= 1'b0;
            tick_2hz_o     <= 1'b0;
            blink_o        <= 1'b1;
            tick_refresh_o <= 1'b0;
        end else begin
            sec_cnt_q      <= sec_cnt_d;
            ref_cnt_q      <= ref_cnt_d;
            tick_1hz_o     <= tick_1hz_d;
            tick_2hz_o     <= tick_2hz_d;
            blink_o        <= blink_d;
            tick_refresh_o <= tick_ref_d;
        end
    end

`ifdef TICKGEN_SPEEDUP_EN
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) spd_q <= 2'd0;
        else       spd_q <= spd_d;
    end
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator at CLK_HZ=2000, REFRESH_HZ=500 (TERM=1999, HALF=999, REF_DIV=4).
// Speed-up scenario runs only when TICKGEN_SPEEDUP_EN is defined.
module tb_tick_generator;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [1:0] speed_sel_i = 2'd0;
    logic       tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o;

    int vectors = 0;
    int miscompares = 0;
    int since_rst;

    tick_generator #(.CLK_HZ(2000), .REFRESH_HZ(500)) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .clr_i          (clr_i),
        .speed_sel_i    (speed_sel_i),
        .tick_1hz_o     (tick_1hz_o),
        .tick_2hz_o     (tick_2hz_o),
        .blink_o        (blink_o),
        .tick_refresh_o (tick_refresh_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release; refresh strobe expected on every 4th one
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    function automatic logic ref_exp();
        return (since_rst != 0) && (since_rst % 4 == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_i = 1'b1;
        en_i  = 1'b1;
        repeat (3) step();
        got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
        vectors++;
        if (got !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset {1hz,2hz,blink,ref} got %b exp %b", got, 4'b0010);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic(input int n);
        logic [3:0] got, exp;
        en_i = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {k % 2000 == 0, k % 1000 == 0, (k % 2000) < 1000, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL basic k=%0d got %b exp %b", k, got, exp);
            end
        end
    endtask

    task automatic test_enable_gap();
        logic [3:0] got, exp;
        en_i = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {1'b0, k == 1000, k < 1000, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gap_pre k=%0d got %b exp %b", k, got, exp);
            end
        end
        en_i = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {1'b0, 1'b0, 1'b0, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gap_hold k=%0d got %b exp %b", k, got, exp);
            end
        end
        en_i = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {k == 500, k == 500, k == 500, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gap_post k=%0d got %b exp %b", k, got, exp);
            end
        end
    endtask

    task automatic test_clear_at_term();
        logic [3:0] got, exp;
        en_i = 1'b1;
        for (int k = 1; k <= 1999; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {1'b0, k == 1000, k < 1000, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL clr_pre k=%0d got %b exp %b", k, got, exp);
            end
        end
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
        exp = {1'b0, 1'b0, 1'b1, ref_exp()};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL clr_at_term got %b exp %b", got, exp);
        end
        test_basic(2000);
    endtask

    task automatic test_async_reset();
        logic [3:0] got, exp;
        en_i = 1'b1;
        for (int k = 1; k <= 1234; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {1'b0, k == 1000, k < 1000, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL arst_pre k=%0d got %b exp %b", k, got, exp);
            end
        end
        #3;
        rst_i = 1'b1;
        #1;
        got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
        vectors++;
        if (got !== 4'b0010) begin
            miscompares++;
            $display("FAIL arst_mid got %b exp %b", got, 4'b0010);
        end
        step();
        rst_i = 1'b0;
        test_basic(2000);
    endtask

`ifdef TICKGEN_SPEEDUP_EN
    task automatic test_speedup();
        logic [3:0] got, exp;
        en_i        = 1'b1;
        speed_sel_i = 2'd3;
        step();
        got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
        exp = {1'b0, 1'b0, 1'b1, ref_exp()};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL spd_restart got %b exp %b", got, exp);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
            exp = {k % 2 == 0, 1'b1, k % 2 == 0, ref_exp()};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL spd_fast k=%0d got %b exp %b", k, got, exp);
            end
        end
        speed_sel_i = 2'd0;
        step();
        got = {tick_1hz_o, tick_2hz_o, blink_o, tick_refresh_o};
        exp = {1'b0, 1'b0, 1'b1, ref_exp()};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL spd_back got %b exp %b", got, exp);
        end
        test_basic(2000);
    endtask
`endif

    initial begin
        test_reset();
        test_basic(4000);
        test_enable_gap();
        test_clear_at_term();
        test_async_reset();
`ifdef TICKGEN_SPEEDUP_EN
        test_speedup();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Parametrised timebase for the digital clock. Derives all system strobes from the board clock.
- Seconds strobe, half-second strobe, 50% colon-blink level and a display-refresh strobe.
- Sits between the board clock and the time counter / display multiplexer.
- Adds over the old 1 Hz divider: generic clock frequency, enable, phase clear, independent refresh channel, and optional set/test speed-up.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz. Must be divisible by 2000.
- REFRESH_HZ, 1000, display-refresh strobe rate. CLK_HZ % REFRESH_HZ == 0 and CLK_HZ/REFRESH_HZ >= 2.
- Derived (localparam, not overridable): SEC_W = $clog2(CLK_HZ), REF_DIV = CLK_HZ/REFRESH_HZ, REF_W = $clog2(REF_DIV).

Ports:
- clk  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  seconds timebase advances while 1
- clr_i  in  1  synchronous restart of seconds phase
- speed_sel_i  in  2  timebase speed select; ignored unless TICKGEN_SPEEDUP_EN
- tick_1hz_o  out  1  one-cycle pulse per (scaled) second
- tick_2hz_o  out  1  one-cycle pulse per (scaled) half second
- blink_o  out  1  50% duty level, high during first half of each second
- tick_refresh_o  out  1  one-cycle pulse at REFRESH_HZ

Behaviour:
- Clock, reset and outputs:
  - Clock clk. Reset rst_i is asynchronous, active-high.
  - All outputs are registered.
  - Reset values: tick_1hz_o=0, tick_2hz_o=0, tick_refresh_o=0, blink_o=1, sec_cnt=0, ref_cnt=0, spd_q=0.
- Seconds terminal count:
  - TERM = CLK_HZ/K - 1, where K = 1, 10, 100, 1000 for spd_q = 0, 1, 2, 3.
  - HALF = (TERM+1)/2 - 1.
  - Without the macro, K=1 always.
- Per-cycle priority for the seconds channel: (1) clr_i, (2) speed change, (3) en_i.
  - clr_i=1: sec_cnt<=0, tick_1hz_o<=0, tick_2hz_o<=0, blink_o<=1. Clear wins over a coincident terminal count; no tick.
  - Speed change (macro only, speed_sel_i != spd_q): spd_q<=speed_sel_i, sec_cnt<=0, blink_o<=1, ticks 0.
  - en_i=1 and sec_cnt==TERM: sec_cnt<=0, tick_1hz_o<=1, tick_2hz_o<=1, blink_o<=1.
  - en_i=1 and sec_cnt==HALF: sec_cnt<=sec_cnt+1, tick_2hz_o<=1, blink_o<=0.
  - en_i=1 otherwise: sec_cnt<=sec_cnt+1, ticks 0.
  - en_i=0: sec_cnt and blink_o hold, ticks 0 (strobes never stretch).
- Timing:
  - tick_1hz_o rises on the edge after the cycle in which sec_cnt==TERM.
  - The first tick after reset/clear is seen TERM+1 enabled cycles later.
- Refresh channel:
  - Free-running ref_cnt counts 0..REF_DIV-1 and wraps.
  - tick_refresh_o<=1 for one cycle when ref_cnt==REF_DIV-1.
  - Unaffected by en_i, clr_i and speed; only rst_i stops it.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), regardless of count.
- Width: counters sized by SEC_W/REF_W; no comparison may truncate. TERM is computed at elaboration as a 32-bit constant per speed.

Optional Feature:
- Macro: TICKGEN_SPEEDUP_EN.
- Defined:
  - speed_sel_i is live; spd_q register and the 4-entry TERM/HALF selection are built.
  - A speed change restarts the seconds phase, as described under Behaviour.
  - Used for fast time-setting and short simulations.
- Undefined:
  - speed_sel_i is present but unconnected internally; spd_q is constant 0.
  - TERM = CLK_HZ-1, HALF = CLK_HZ/2-1.
  - No speed-change restart logic is built.

Test Plan:
Bench parameters: CLK_HZ=2000, REFRESH_HZ=500 (TERM=1999, HALF=999, REF_DIV=4).
- Reset release, en_i=1 for 4000 cycles:
  - tick_1hz_o high exactly at cycles 2000 and 4000 after release; tick_2hz_o at 1000, 2000, 3000, 4000.
  - blink_o high for 1000 cycles, then low for 1000 cycles.
- Refresh: tick_refresh_o pulses every 4 cycles from cycle 4, continuing through en_i=0 and clr_i=1 windows.
- en_i dropped at sec_cnt=1500 for 300 cycles:
  - No ticks while low; blink_o holds 0.
  - Next tick_1hz_o arrives 500 enabled cycles after re-enable.
- clr_i asserted in the same cycle as sec_cnt==1999: no tick_1hz_o/tick_2hz_o, blink_o=1, next tick_1hz_o 2000 cycles later.
- rst_i pulsed asynchronously mid-count (sec_cnt=1234, between edges): all outputs take reset values before the next edge; sequence restarts as in the first scenario.
- TICKGEN_SPEEDUP_EN, speed_sel_i=3:
  - One-cycle restart, then tick_1hz_o every 2 cycles and tick_2hz_o every cycle.
  - blink_o alternates each cycle.
  - Switching back to 0 restarts the phase; next tick_1hz_o after 2000 cycles.
